// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: shared flip-flop mode enum and SR/JK input encodings.
package ff_bank_pkg;
  typedef enum logic [1:0] {
    FF_D  = 2'b00,
    FF_T  = 2'b01,
    FF_SR = 2'b10,
    FF_JK = 2'b11
  } ff_mode_t;
  localparam logic [1:0] AB_HOLD = 2'b00;
  localparam logic [1:0] AB_RST  = 2'b01;
  localparam logic [1:0] AB_SET  = 2'b10;
  localparam logic [1:0] AB_BOTH = 2'b11;
endpackage

// File: rtl/ff_bank_if.sv
// ff_bank_if: control/data bundle for ff_bank; ill_cnt present only with FF_BANK_ILL_CNT_EN.
interface ff_bank_if
  import ff_bank_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef FF_BANK_ILL_CNT_EN
  , parameter int CNT_W = 8
`endif
);
  logic             en;
  ff_mode_t         mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] err;
  logic             err_any;
`ifdef FF_BANK_ILL_CNT_EN
  logic [CNT_W-1:0] ill_cnt;
`endif
  modport master (
    output en, mode, a, b, err_clr,
    input  q, qn, err, err_any
`ifdef FF_BANK_ILL_CNT_EN
    , input ill_cnt
`endif
  );
  modport slave (
    input  en, mode, a, b, err_clr,
    output q, qn, err, err_any
`ifdef FF_BANK_ILL_CNT_EN
    , output ill_cnt
`endif
  );
endinterface

// File: rtl/ff_cell.sv
// ff_cell: next-state and SR-illegal strobe for one selectable-personality flip-flop bit.
module ff_cell
  import ff_bank_pkg::*;
(
  input  ff_mode_t mode,
  input  logic     q,
  input  logic     a,
  input  logic     b,
  output logic     nxt,
  output logic     ill
);
  logic [1:0] ab;
  logic       jk;
  assign ab  = {a, b};
  assign jk  = ab == AB_RST ? 1'b0 : ab == AB_SET ? 1'b1 : ab == AB_BOTH ? ~q : q;
  assign ill = mode == FF_SR && ab == AB_BOTH;
  // SR shares the JK table except that S=R=1 holds instead of toggling
  assign nxt = mode == FF_D ? a : mode == FF_T ? q ^ a : ill ? q : jk;
endmodule

// File: rtl/ff_bank.sv
// ff_bank: WIDTH D/T/SR/JK flip-flops with sticky SR-illegal flags; FF_BANK_ILL_CNT_EN adds ill_cnt.
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
`ifdef FF_BANK_ILL_CNT_EN
  , parameter int             CNT_W   = 8
`endif
) (
  input logic      clk,
  input logic      rst,
  ff_bank_if.slave bus
);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] err;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ill;
  logic             evt;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .mode (bus.mode),
      .q    (q[i]),
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .nxt  (nxt[i]),
      .ill  (ill[i])
    );
  end
  assign evt = |ill;
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= RST_VAL;
      err <= '0;
    end else if (bus.en) begin
      q   <= nxt;
      err <= (bus.err_clr ? '0 : err) | ill;
    end
  end
`ifdef FF_BANK_ILL_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (bus.en) cnt <= bus.err_clr ? CNT_W'(evt) : (evt && !(&cnt)) ? cnt + 1'b1 : cnt;
  end
  assign bus.ill_cnt = cnt;
`else
  logic unused_evt;
  assign unused_evt = evt;
`endif
  assign bus.q       = q;
  assign bus.qn      = ~q;
  assign bus.err     = err;
  assign bus.err_any = |err;
endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: directed vectors push expected state into a scoreboard; a monitor pops and checks each cycle.
module tb_ff_bank;
  import ff_bank_pkg::*;
  typedef struct {
    logic [7:0] q;
    logic [7:0] err;
    logic [7:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];
  always #5 clk = ~clk;
`ifdef FF_BANK_ILL_CNT_EN
  ff_bank_if #(.WIDTH(8), .CNT_W(8)) bus ();
  ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  ff_bank_if #(.WIDTH(8), .CNT_W(2)) bus2 ();
  assign bus2.en      = bus.en;
  assign bus2.mode    = bus.mode;
  assign bus2.a       = bus.a;
  assign bus2.b       = bus.b;
  assign bus2.err_clr = bus.err_clr;
  ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
`else
  ff_bank_if #(.WIDTH(8)) bus ();
  ff_bank #(.WIDTH(8), .RST_VAL(8'hA5)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic e, input ff_mode_t m, input logic [7:0] aa,
                      input logic [7:0] bb, input logic c, input logic [7:0] eq,
                      input logic [7:0] ee, input logic [7:0] ec);
    @(negedge clk);
    rst = r;
    bus.en = e;
    bus.mode = m;
    bus.a = aa;
    bus.b = bb;
    bus.err_clr = c;
    sbq.push_back('{q: eq, err: ee, cnt: ec});
  endtask
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk("q", bus.q, x.q);
      chk("qn", bus.qn, ~x.q);
      chk("err", bus.err, x.err);
      chk("err_any", {7'b0, bus.err_any}, {7'b0, |x.err});
`ifdef FF_BANK_ILL_CNT_EN
      chk("ill_cnt", bus.ill_cnt, x.cnt);
`endif
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.mode = FF_D;
    bus.a = '0;
    bus.b = '0;
    bus.err_clr = 1'b0;
    step(1, 0, FF_D,  8'h00, 8'h00, 0, 8'hA5, 8'h00, 8'd0);
    step(1, 1, FF_D,  8'hFF, 8'h00, 0, 8'hA5, 8'h00, 8'd0);
    step(0, 1, FF_D,  8'h3C, 8'h00, 0, 8'h3C, 8'h00, 8'd0);
    step(0, 0, FF_D,  8'hFF, 8'h00, 0, 8'h3C, 8'h00, 8'd0);
    step(0, 1, FF_D,  8'h0F, 8'h00, 0, 8'h0F, 8'h00, 8'd0);
    step(0, 1, FF_T,  8'hFF, 8'h00, 0, 8'hF0, 8'h00, 8'd0);
    step(0, 1, FF_T,  8'hFF, 8'h00, 0, 8'h0F, 8'h00, 8'd0);
    step(0, 1, FF_D,  8'h00, 8'h00, 0, 8'h00, 8'h00, 8'd0);
    step(0, 1, FF_JK, 8'hF0, 8'h0F, 0, 8'hF0, 8'h00, 8'd0);
    step(0, 1, FF_JK, 8'hFF, 8'hFF, 0, 8'h0F, 8'h00, 8'd0);
    step(0, 1, FF_JK, 8'h00, 8'h00, 0, 8'h0F, 8'h00, 8'd0);
    step(0, 1, FF_D,  8'h00, 8'h00, 0, 8'h00, 8'h00, 8'd0);
    step(0, 1, FF_SR, 8'h03, 8'h01, 0, 8'h02, 8'h01, 8'd1);
    step(0, 1, FF_SR, 8'h03, 8'h01, 0, 8'h02, 8'h01, 8'd2);
    step(0, 1, FF_SR, 8'h03, 8'h01, 0, 8'h02, 8'h01, 8'd3);
    step(0, 1, FF_SR, 8'h03, 8'h01, 0, 8'h02, 8'h01, 8'd4);
    step(0, 1, FF_SR, 8'h00, 8'h00, 1, 8'h02, 8'h00, 8'd0);
    step(0, 1, FF_SR, 8'h80, 8'h80, 1, 8'h02, 8'h80, 8'd1);
    step(0, 0, FF_SR, 8'hFF, 8'hFF, 1, 8'h02, 8'h80, 8'd1);
    step(0, 1, FF_SR, 8'hFF, 8'hFF, 0, 8'h02, 8'hFF, 8'd2);
    step(1, 1, FF_SR, 8'hFF, 8'hFF, 0, 8'hA5, 8'h00, 8'd0);
    step(0, 0, FF_SR, 8'hFF, 8'hFF, 0, 8'hA5, 8'h00, 8'd0);
    step(0, 1, FF_SR, 8'h01, 8'h01, 0, 8'hA5, 8'h01, 8'd1);
    step(0, 1, FF_SR, 8'h01, 8'h01, 0, 8'hA5, 8'h01, 8'd2);
    step(0, 1, FF_SR, 8'h01, 8'h01, 0, 8'hA5, 8'h01, 8'd3);
    step(0, 1, FF_SR, 8'h01, 8'h01, 0, 8'hA5, 8'h01, 8'd4);
    step(0, 1, FF_SR, 8'h01, 8'h01, 0, 8'hA5, 8'h01, 8'd5);
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #2;
`ifdef FF_BANK_ILL_CNT_EN
    chk("ill_cnt_sat", {6'b0, bus2.ill_cnt}, 8'd3);
`endif
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ff_bank.md
# ff_bank

Parametrised bank of WIDTH independent single-bit flip-flops sharing one clock, enable and run-time mode select. Each bit behaves as a D, T, SR or JK flip-flop. qn is always the exact complement of q. Illegal SR input combinations are detected and recorded in sticky per-bit error flags. The block replaces single-bit SR/D flip-flop instances wherever a register group needs a selectable flip-flop personality.

## Interface
Parameters:
- WIDTH, 8, number of flip-flop bits (1..64)
- RST_VAL, '0, WIDTH-bit reset value of q
- CNT_W, 8, width of illegal-event counter (only with FF_BANK_ILL_CNT_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- en  in  1  update enable; 0 = all bits hold
- mode  in  2  flip-flop type for all bits: 00 D, 01 T, 10 SR, 11 JK
- a  in  WIDTH  per-bit primary input (D / T / S / J)
- b  in  WIDTH  per-bit secondary input (R / K); ignored in D and T
- err_clr  in  1  clears sticky error flags (and counter)
- q  out  WIDTH  flip-flop state
- qn  out  WIDTH  always ~q, including during and after reset
- err  out  WIDTH  sticky per-bit SR-illegal flag
- err_any  out  1  OR of err
- ill_cnt  out  CNT_W  illegal-event cycle count (only with FF_BANK_ILL_CNT_EN)

## Operation
- Reset (rst=1 at edge): q=RST_VAL, qn=~RST_VAL, err=0, err_any=0, ill_cnt=0. Reset overrides en, mode, a, b and err_clr.
- en=0: q, err and ill_cnt hold. No illegal detection occurs.
- en=1, per bit i, by mode sampled at the same edge:
  - D: q[i]<=a[i]
  - T: q[i]<=q[i]^a[i]
  - SR (a=S, b=R): 00 hold; 01 q<=0; 10 q<=1; 11 hold and flag illegal
  - JK (a=J, b=K): 00 hold; 01 q<=0; 10 q<=1; 11 q<=~q
- Illegal event on bit i = en & mode==SR & a[i] & b[i]. It sets err[i].
- err[i] clears on err_clr. If err_clr and a new illegal event on bit i occur in the same cycle, the set wins and err[i]=1.
- Mode changes take effect at the edge where they are sampled. No state conversion occurs; q carries over unchanged.
- qn is derived from the q register, never assigned independently, so qn==~q holds at every cycle.

## Timing
- q/qn latency: 1 cycle from sampled inputs. Outputs are registered.
- err latency: 1 cycle after the illegal input. err_any is combinational from the err register, so it has the same latency.
- ill_cnt latency: 1 cycle.
- Inputs are sampled only at the rising edge. There is no combinational path from a, b or mode to any output.
- Reset mid-operation: state and error flags are lost at that edge. The first post-reset update happens at the first edge with rst=0.

## Configuration
- FF_BANK_ILL_CNT_EN defined:
  - ill_cnt exists.
  - It increments by 1 on each cycle in which at least one bit has an illegal event.
  - It saturates at all-ones.
  - err_clr zeroes it. If err_clr coincides with an event, ill_cnt becomes 1.
- Not defined: the ill_cnt port and counter are absent. All other behaviour is identical.

## Structure
- Shared package ff_bank_pkg holds:
  - the ff_mode_t enum (FF_D=2'b00, FF_T=2'b01, FF_SR=2'b10, FF_JK=2'b11)
  - next-state function constants
- Sub-module ff_cell: one bit, computing next q and the illegal strobe. It is instantiated WIDTH times via generate.
- The top level holds the en gating, the err register, err_any and the optional counter.

## Test plan
- Reset with RST_VAL=8'hA5, rst=1 two cycles -> q=8'hA5, qn=8'h5A, err=0, ill_cnt=0. qn==~q checked every cycle of every test.
- D mode, en=1, a=8'h3C -> q=8'h3C next cycle. Then en=0, a=8'hFF -> q stays 8'h3C.
- T mode, q=8'h0F, a=8'hFF for 2 cycles -> q=8'hF0 then 8'h0F.
- JK mode, q=8'h00, a=8'hF0, b=8'h0F -> q=8'hF0. Then a=b=8'hFF -> q=8'h0F. Then a=b=0 -> holds 8'h0F.
- SR mode, q=8'h00, a=8'h03, b=8'h01 -> q=8'h02, err=8'h01, err_any=1, ill_cnt=1. Three more identical cycles -> ill_cnt=4. err_clr with a=b=0 -> err=0, ill_cnt=0.
- Corner cases:
  - err_clr coinciding with an illegal event on bit 7 -> err=8'h80, ill_cnt=1.
  - CNT_W=2 with 5 event cycles -> ill_cnt=3 (saturated).
  - rst asserted with err=8'hFF -> err=0 next cycle.
